sssp_mem_resp_splitter: RTL and testbench
=========================================

# sssp_mem_resp_splitter

Memory-read responder for the SSSP worker pipeline. Accepts read requests from the worker (address, size, burst length and a task template), issues AXI4 read bursts to the 64-bit memory port, and converts each returned data beat into a per-word task carrying the template task, data word, word index, subtype and last mark. Its output feeds the worker task FIFO for the next subtype stage.

## Interface
- DEPTH, 8: maximum outstanding requests (context FIFO entries); power of two, at least 2.
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_addr  in  32  byte address
- req_size  in  3  2 = 4-byte words, 3 = 8-byte words; other values are illegal
- req_len  in  8  words minus one (1..256 words)
- req_task  in  task_t  template copied to every generated task
- req_subtype  in  subtype_t  subtype of every generated task
- req_mark_last  in  1  set out_last on the final word of this request
- m_arvalid / m_arready  out / in  1  AXI read address handshake
- m_araddr  out  32  burst address
- m_arlen  out  8  burst beats minus one
- m_arsize  out  3  equals req_size
- m_arburst  out  2  constant 2'b01 (INCR)
- m_rvalid / m_rready  in / out  1  AXI read data handshake
- m_rdata  in  64  beat data
- m_rlast  in  1  ignored; the beat count is authoritative
- out_valid / out_ready  out / in  1  generated-task handshake
- out_task  out  task_t  copy of req_task
- out_data  out  data_t (64)  word; zero-extended when size = 2
- out_word_id  out  byte_t (8)  word index within the request, from 0
- out_subtype  out  subtype_t  copy of req_subtype
- out_last  out  1  req_mark_last & final word

## Operation
- Acceptance: req_ready = (ar_state == AR_IDLE) & context FIFO not full. On accept:
  - Push context {task, subtype, mark_last, size, addr[2], total = req_len+1}.
  - Latch the burst parameters.
- Address alignment: addr[1:0] is ignored for size 2; addr[2:0] is ignored for size 3.
- AR FSM:
  - AR_IDLE -> AR_FIRST on accept.
  - AR_FIRST holds m_arvalid high until m_arready. It then returns to AR_IDLE, or goes to AR_SECOND when a split is needed.
  - AR_SECOND issues the second burst, then returns to AR_IDLE.
- 4 KB rule:
  - bytes = (req_len+1) << req_size; the maximum is 2048, so at most one split is needed.
  - A split occurs when addr[11:0] + bytes > 4096.
  - First burst: len = ((4096 - addr[11:0]) >> size) - 1.
  - Second burst: address = addr[31:12]+1 concatenated with 12'h000; len = req_len - first_len - 1.
  - m_araddr is the aligned address.
- R side:
  - Operates on the FIFO head context.
  - An 8-bit beat counter counts words for the whole request across both bursts.
  - Lane select for size 2: lane = addr[2] XOR count[0]. Lane 0 is rdata[31:0]; lane 1 is rdata[63:32].
  - On the beat where count == total-1: pop the context, reset count to 0, and set out_last = mark_last.
- No m_rvalid is expected while the FIFO is empty. Such a beat is accepted and dropped.
- Arithmetic: all address math is 32-bit unsigned. Word ids wrap modulo 256, but the maximum is 255, so no wrap occurs.

## Timing
- Reset values: req_ready 0 during reset, m_arvalid 0, m_rready 0, out_valid 0, and all out_* data fields 0. The FIFO is empty, the counter is 0, and the FSM is AR_IDLE. Reset mid-operation discards all context; the system must not have reads in flight across reset.
- Request acceptance to m_arvalid: 1 cycle. m_araddr, m_arlen and m_arsize are stable while m_arvalid is high and unacknowledged.
- After the first burst's m_arready, the second burst's m_arvalid is asserted in the next cycle.
- After AR_IDLE returns, req_ready may rise the same cycle if the FIFO is not full. There is no bubble beyond the FSM.
- Output register:
  - m_rready = !out_valid | out_ready.
  - An accepted beat appears on out_* in the next cycle, giving 1-cycle latency.
  - Full throughput is one word per cycle.
  - out_* is held stable while out_valid & !out_ready.
- Simultaneous FIFO push and pop in one cycle are both performed. The full flag only accounts for occupancy before the push.

## Test plan
- Size 3, addr 0x1000, len 3, mark_last=1 -> one burst (araddr 0x1000, arlen 3). Four tasks result with word_id 0..3 and out_data equal to the beats; out_last is set only on word 3.
- Size 2, addr 0x2004, len 2, beats D0..D2 -> out_data is D0[63:32], D1[31:0], D2[63:32], zero-extended.
- 4 KB split: size 3, addr 0x0FF0, len 5 -> burst 0x0FF0/arlen 1, then 0x1000/arlen 3. word_id runs 0..5 continuously and out_last falls on word 5 only.
- Backpressure: hold out_ready low for 5 cycles mid-burst -> m_rready drops, out_* is held, and no word is lost or duplicated.
- DEPTH=8: issue 9 requests while m_rvalid is held low -> req_ready drops after 8. It reasserts in the cycle after the first request's final beat is accepted.
- mark_last=0, len 0 -> a single task with word_id 0 and out_last 0. The context is popped and the next request's beats start at word_id 0.

Source files
------------

// File: rtl/sssp_mem_resp_splitter.sv
// rtl/sssp_mem_resp_splitter.sv - memory read responder: AXI4 read bursts in, per-word worker tasks out
//
// Accepts worker read requests, issues one or two INCR bursts (split at a 4 KB
// page), and turns every returned data beat into a task word for the next
// subtype stage.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   req_*                     request handshake: address, size (2/3), len (words-1),
//                             task template, subtype, mark_last
//   m_ar*                     AXI4 read address channel (INCR bursts)
//   m_r*                      AXI4 read data channel (m_rlast unused, beat count rules)
//   out_*                     generated task: template, data word, word id, subtype, last
module sssp_mem_resp_splitter #(
  parameter int DEPTH     = 8,
  parameter int TASK_W    = 32,
  parameter int SUBTYPE_W = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_addr,
  input  logic [2:0]           req_size,
  input  logic [7:0]           req_len,
  input  logic [TASK_W-1:0]    req_task,
  input  logic [SUBTYPE_W-1:0] req_subtype,
  input  logic                 req_mark_last,
  output logic                 m_arvalid,
  input  logic                 m_arready,
  output logic [31:0]          m_araddr,
  output logic [7:0]           m_arlen,
  output logic [2:0]           m_arsize,
  output logic [1:0]           m_arburst,
  input  logic                 m_rvalid,
  output logic                 m_rready,
  input  logic [63:0]          m_rdata,
  input  logic                 m_rlast,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TASK_W-1:0]    out_task,
  output logic [63:0]          out_data,
  output logic [7:0]           out_word_id,
  output logic [SUBTYPE_W-1:0] out_subtype,
  output logic                 out_last
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {AR_IDLE, AR_FIRST, AR_SECOND} ar_state_t;

  typedef struct packed {
    logic [TASK_W-1:0]    tmpl;
    logic [SUBTYPE_W-1:0] subtype;
    logic                 mark_last;
    logic                 size3;
    logic                 addr2;
    logic [7:0]           len;   // total words minus one
  } ctx_t;

  // ---------------- state ----------------
  ar_state_t           ar_state_q, ar_state_d;
  logic [31:0]         ar_addr_q, ar_addr_d;
  logic [7:0]          ar_len_q, ar_len_d;
  logic [2:0]          ar_size_q, ar_size_d;
  logic                split_q, split_d;
  logic [31:0]         sec_addr_q, sec_addr_d;
  logic [7:0]          sec_len_q, sec_len_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         occ_q, occ_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [TASK_W-1:0]   out_task_q, out_task_d;
  logic [63:0]         out_data_q, out_data_d;
  logic [7:0]          out_word_id_q, out_word_id_d;
  logic [SUBTYPE_W-1:0] out_subtype_q, out_subtype_d;
  logic                out_last_q, out_last_d;

  ctx_t ctx_mem_q [DEPTH];

  // ---------------- request-side burst planning ----------------
  logic        req_size3, push, pop, beat_fire, have_ctx, split;
  logic [31:0] req_aligned, second_addr;
  logic [8:0]  req_words;
  logic [12:0] req_bytes, page_off, room, first_words;
  logic [13:0] req_end;
  logic [7:0]  first_len, second_len;
  ctx_t        req_ctx, rd_ctx;
  logic        lane_hi;
  logic [63:0] beat_word;

  assign req_size3   = (req_size == 3'd3);
  assign req_aligned = req_size3 ? {req_addr[31:3], 3'b000} : {req_addr[31:2], 2'b00};
  assign req_words   = {1'b0, req_len} + 9'd1;
  assign req_bytes   = req_size3 ? {1'b0, req_words, 3'b000} : {2'b00, req_words, 2'b00};
  assign page_off    = {1'b0, req_aligned[11:0]};
  assign req_end     = {1'b0, page_off} + {1'b0, req_bytes};
  assign split       = (req_end > 14'd4096);
  assign room        = 13'd4096 - page_off;
  // When a split happens the first burst holds fewer words than the request,
  // so first_words always fits in 8 bits.
  assign first_words = req_size3 ? (room >> 3) : (room >> 2);
  assign first_len   = first_words[7:0] - 8'd1;
  assign second_len  = req_len - first_len - 8'd1;
  assign second_addr = {req_addr[31:12] + 20'd1, 12'h000};

  assign req_ctx = '{tmpl: req_task, subtype: req_subtype, mark_last: req_mark_last,
                     size3: req_size3, addr2: req_aligned[2], len: req_len};

  assign req_ready = rstn & (ar_state_q == AR_IDLE) & (occ_q != FULL_OCC);
  assign push      = req_valid & req_ready;

  // ---------------- R side ----------------
  assign rd_ctx    = ctx_mem_q[rd_ptr_q];
  assign have_ctx  = (occ_q != '0);
  assign m_rready  = rstn & (~out_valid_q | out_ready);
  assign beat_fire = m_rvalid & m_rready;
  assign pop       = beat_fire & have_ctx & (cnt_q == rd_ctx.len);
  // Word address bit 2 advances with each 4-byte word, so the lane alternates.
  assign lane_hi   = rd_ctx.addr2 ^ cnt_q[0];
  assign beat_word = rd_ctx.size3 ? m_rdata
                                  : {32'h0, lane_hi ? m_rdata[63:32] : m_rdata[31:0]};

  always_comb begin
    ar_state_d    = ar_state_q;
    ar_addr_d     = ar_addr_q;
    ar_len_d      = ar_len_q;
    ar_size_d     = ar_size_q;
    split_d       = split_q;
    sec_addr_d    = sec_addr_q;
    sec_len_d     = sec_len_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    occ_d         = occ_q;
    cnt_d         = cnt_q;
    out_valid_d   = out_valid_q & ~out_ready;
    out_task_d    = out_task_q;
    out_data_d    = out_data_q;
    out_word_id_d = out_word_id_q;
    out_subtype_d = out_subtype_q;
    out_last_d    = out_last_q;

    case (ar_state_q)
      AR_IDLE: begin
        if (push) begin
          ar_state_d = AR_FIRST;
          ar_addr_d  = req_aligned;
          ar_len_d   = split ? first_len : req_len;
          ar_size_d  = req_size;
          split_d    = split;
          sec_addr_d = second_addr;
          sec_len_d  = second_len;
        end
      end
      AR_FIRST: begin
        if (m_arready) begin
          if (split_q) begin
            ar_state_d = AR_SECOND;
            ar_addr_d  = sec_addr_q;
            ar_len_d   = sec_len_q;
          end else begin
            ar_state_d = AR_IDLE;
          end
        end
      end
      AR_SECOND: begin
        if (m_arready) ar_state_d = AR_IDLE;
      end
      default: ar_state_d = AR_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    occ_d = occ_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    // Beats arriving with no context are consumed and dropped.
    if (beat_fire && have_ctx) begin
      out_valid_d   = 1'b1;
      out_task_d    = rd_ctx.tmpl;
      out_data_d    = beat_word;
      out_word_id_d = cnt_q;
      out_subtype_d = rd_ctx.subtype;
      out_last_d    = pop & rd_ctx.mark_last;
      cnt_d         = pop ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ar_state_q    <= AR_IDLE;
      ar_addr_q     <= '0;
      ar_len_q      <= '0;
      ar_size_q     <= '0;
      split_q       <= 1'b0;
      sec_addr_q    <= '0;
      sec_len_q     <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      out_task_q    <= '0;
      out_data_q    <= '0;
      out_word_id_q <= '0;
      out_subtype_q <= '0;
      out_last_q    <= 1'b0;
    end else begin
      ar_state_q    <= ar_state_d;
      ar_addr_q     <= ar_addr_d;
      ar_len_q      <= ar_len_d;
      ar_size_q     <= ar_size_d;
      split_q       <= split_d;
      sec_addr_q    <= sec_addr_d;
      sec_len_q     <= sec_len_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      out_task_q    <= out_task_d;
      out_data_q    <= out_data_d;
      out_word_id_q <= out_word_id_d;
      out_subtype_q <= out_subtype_d;
      out_last_q    <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) ctx_mem_q[wr_ptr_q] <= req_ctx;
  end

  assign m_arvalid   = (ar_state_q != AR_IDLE);
  assign m_araddr    = ar_addr_q;
  assign m_arlen     = ar_len_q;
  assign m_arsize    = ar_size_q;
  assign m_arburst   = 2'b01;
  assign out_valid   = out_valid_q;
  assign out_task    = out_task_q;
  assign out_data    = out_data_q;
  assign out_word_id = out_word_id_q;
  assign out_subtype = out_subtype_q;
  assign out_last    = out_last_q;

  logic unused_bits;
  assign unused_bits = ^{m_rlast, req_addr[1:0], first_words[12:8]};

endmodule

// File: tb/tb_sssp_mem_resp_splitter.sv
// tb/tb_sssp_mem_resp_splitter.sv - scoreboard bench for sssp_mem_resp_splitter
module tb_sssp_mem_resp_splitter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_len;
  logic [31:0] req_task;
  logic [3:0]  req_subtype;
  logic        req_mark_last;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rvalid, m_rready, m_rlast;
  logic [63:0] m_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_task;
  logic [63:0] out_data;
  logic [7:0]  out_word_id;
  logic [3:0]  out_subtype;
  logic        out_last;

  sssp_mem_resp_splitter #(.DEPTH(8), .TASK_W(32), .SUBTYPE_W(4)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_len(req_len), .req_task(req_task),
    .req_subtype(req_subtype), .req_mark_last(req_mark_last),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast),
    .out_valid(out_valid), .out_ready(out_ready), .out_task(out_task),
    .out_data(out_data), .out_word_id(out_word_id), .out_subtype(out_subtype),
    .out_last(out_last)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
  } ar_exp_t;

  typedef struct {
    logic [31:0] tmpl;
    logic [63:0] data;
    logic [7:0]  id;
    logic [3:0]  st;
    logic        last;
  } out_exp_t;

  ar_exp_t     exp_ar[$];
  out_exp_t    exp_out[$];
  logic [63:0] beat_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        r_en = 1'b0;

  // Memory-side beat source: presents queued beats when enabled.
  always @(posedge clk) begin
    #1;
    if (r_en && beat_q.size() > 0) begin
      m_rvalid = 1'b1;
      m_rdata  = beat_q[0];
    end else begin
      m_rvalid = 1'b0;
      m_rdata  = '0;
    end
  end

  always @(negedge clk) begin
    if (m_rvalid && m_rready) void'(beat_q.pop_front());
  end

  // Scoreboard: AR bursts and generated tasks, sampled mid-cycle.
  always @(negedge clk) begin
    ar_exp_t  ea;
    out_exp_t eo;
    if (rstn && m_arvalid && m_arready) begin
      n_vec++;
      if (exp_ar.size() == 0) begin
        n_err++;
        $display("FAIL ar_unexpected: got addr=%h len=%0d, expected no burst", m_araddr, m_arlen);
      end else begin
        ea = exp_ar.pop_front();
        if (m_araddr !== ea.addr || m_arlen !== ea.len || m_arsize !== ea.size || m_arburst !== 2'b01) begin
          n_err++;
          $display("FAIL ar_burst: got addr=%h len=%0d size=%0d burst=%b, expected addr=%h len=%0d size=%0d burst=01",
                   m_araddr, m_arlen, m_arsize, m_arburst, ea.addr, ea.len, ea.size);
        end
      end
    end
    if (rstn && out_valid && out_ready) begin
      n_vec++;
      if (exp_out.size() == 0) begin
        n_err++;
        $display("FAIL out_unexpected: got data=%h id=%0d, expected no task", out_data, out_word_id);
      end else begin
        eo = exp_out.pop_front();
        if (out_task !== eo.tmpl || out_data !== eo.data || out_word_id !== eo.id ||
            out_subtype !== eo.st || out_last !== eo.last) begin
          n_err++;
          $display("FAIL out_task: got task=%h data=%h id=%0d st=%0d last=%b, expected task=%h data=%h id=%0d st=%0d last=%b",
                   out_task, out_data, out_word_id, out_subtype, out_last,
                   eo.tmpl, eo.data, eo.id, eo.st, eo.last);
        end
      end
    end
  end

  // Presents one request, waits for acceptance, then loads the expected bursts,
  // the beats to return and the expected tasks.
  task automatic send_req(input logic [31:0] addr, input logic [2:0] size,
                          input logic [7:0] len, input logic mark, input logic [3:0] st);
    int          wb, room, nbytes, first;
    logic [31:0] al, tmpl;
    logic [63:0] b;
    bit          ok;
    ar_exp_t     ea;
    out_exp_t    eo;
    tmpl = $urandom;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = addr; req_size = size; req_len = len;
    req_task = tmpl; req_subtype = st; req_mark_last = mark;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin ok = 1; break; end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL req_accept: addr=%h never accepted, expected req_ready=1", addr);
      @(posedge clk); #1; req_valid = 1'b0;
      return;
    end
    wb     = (size == 3'd3) ? 8 : 4;
    al     = addr - (addr % wb);
    nbytes = (int'(len) + 1) * wb;
    room   = 4096 - int'(al % 4096);
    ea.size = size;
    if (nbytes > room) begin
      first   = room / wb;
      ea.addr = al; ea.len = 8'(first - 1);
      exp_ar.push_back(ea);
      ea.addr = al - (al % 4096) + 4096; ea.len = 8'(int'(len) - first);
      exp_ar.push_back(ea);
    end else begin
      ea.addr = al; ea.len = len;
      exp_ar.push_back(ea);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      b = {$urandom, $urandom};
      beat_q.push_back(b);
      eo.tmpl = tmpl; eo.st = st; eo.id = 8'(i);
      eo.last = mark && (i == int'(len));
      if (size == 3'd3) eo.data = b;
      else if (((al + 32'(4 * i)) % 8) >= 4) eo.data = {32'h0, b[63:32]};
      else eo.data = {32'h0, b[31:0]};
      exp_out.push_back(eo);
    end
    @(negedge clk);
    n_vec++;
    if (m_arvalid !== 1'b1) begin
      n_err++;
      $display("FAIL ar_latency: m_arvalid=%b one cycle after accept, expected 1", m_arvalid);
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while ((exp_out.size() != 0 || exp_ar.size() != 0 || beat_q.size() != 0) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k >= 1000) begin
      n_err++;
      $display("FAIL %s_drain: %0d tasks %0d bursts outstanding, expected 0", name, exp_out.size(), exp_ar.size());
      exp_out.delete(); exp_ar.delete(); beat_q.delete();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b, expected 0", req_ready); end
    n_vec++; if (m_arvalid !== 1'b0) begin n_err++; $display("FAIL rst_arvalid: got %b, expected 0", m_arvalid); end
    n_vec++; if (m_rready !== 1'b0) begin n_err++; $display("FAIL rst_rready: got %b, expected 0", m_rready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
    n_vec++;
    if (out_data !== 64'h0 || out_task !== 32'h0 || out_word_id !== 8'h0 || out_subtype !== 4'h0 || out_last !== 1'b0) begin
      n_err++;
      $display("FAIL rst_out_fields: data=%h task=%h id=%0d st=%0d last=%b, expected all 0",
               out_data, out_task, out_word_id, out_subtype, out_last);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_req_ready: got %b, expected 1", req_ready); end
    n_vec++; if (m_rready !== 1'b1) begin n_err++; $display("FAIL post_rst_rready: got %b, expected 1", m_rready); end
  endtask

  task automatic test_single();
    send_req(32'h0000_1000, 3'd3, 8'd3, 1'b1, 4'd1);
    wait_drain("single");
  endtask

  task automatic test_size2();
    send_req(32'h0000_2004, 3'd2, 8'd2, 1'b1, 4'd2);
    wait_drain("size2");
    send_req(32'h0000_2803, 3'd2, 8'd4, 1'b0, 4'd3);
    wait_drain("size2_unaligned");
  endtask

  task automatic test_split();
    send_req(32'h0000_0FF0, 3'd3, 8'd5, 1'b1, 4'd4);
    wait_drain("split8");
    send_req(32'h0001_3FF4, 3'd2, 8'd255, 1'b1, 4'd5);
    wait_drain("split4");
  endtask

  task automatic test_backpressure();
    int k;
    send_req(32'h0000_3000, 3'd2, 8'd15, 1'b1, 4'd6);
    k = 0;
    while (exp_out.size() > 8 && k < 200) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (m_rready !== 1'b0 || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold: m_rready=%b out_valid=%b, expected 0 and 1", m_rready, out_valid);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_drain("backpressure");
  endtask

  task automatic test_depth();
    @(posedge clk); #1;
    r_en = 1'b0;
    for (int i = 0; i < 8; i++) send_req(32'h0000_7000 + 32'(i * 256), 3'd3, 8'd1, 1'b1, 4'(i));
    fork
      send_req(32'h0000_8000, 3'd3, 8'd1, 1'b1, 4'd9);
      begin
        int  hs;
        bit  done;
        hs = 0; done = 0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b0) begin n_err++; $display("FAIL depth_full: req_ready=%b, expected 0", req_ready); end
        @(posedge clk); #1;
        r_en = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
          @(negedge clk);
          if (m_rvalid && m_rready) begin
            hs++;
            if (hs == 2) begin
              n_vec++;
              if (req_ready !== 1'b0) begin n_err++; $display("FAIL depth_last_beat: req_ready=%b, expected 0", req_ready); end
              @(negedge clk);
              n_vec++;
              if (req_ready !== 1'b1) begin n_err++; $display("FAIL depth_reassert: req_ready=%b, expected 1", req_ready); end
              done = 1;
            end
          end
        end
        if (!done) begin n_vec++; n_err++; $display("FAIL depth_timeout: beats=%0d, expected 2", hs); end
      end
    join
    wait_drain("depth");
  endtask

  task automatic test_len0_nolast();
    send_req(32'h0000_5008, 3'd3, 8'd0, 1'b0, 4'd7);
    send_req(32'h0000_6000, 3'd3, 8'd1, 1'b1, 4'd8);
    wait_drain("len0");
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0; req_len = '0;
    req_task = '0; req_subtype = '0; req_mark_last = 1'b0;
    m_arready = 1'b1; m_rvalid = 1'b0; m_rdata = '0; m_rlast = 1'b0; out_ready = 1'b1;
    test_reset();
    r_en = 1'b1;
    test_single();
    test_size2();
    test_split();
    test_backpressure();
    test_depth();
    test_len0_nolast();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
